// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first.
// Define SERIAL_SUB_SAT_EN to clamp d to zero when the final borrow is set.
module serial_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             a_msb;
    logic             b_msb;

    logic             accept;
    logic             finish;
    logic             diff_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] d_raw;
    logic             ovf_raw;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A start seen in the completion cycle chains straight into the next run.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // ---------------------------------------------------------------
    // Full-subtractor cell and completed-result view
    // ---------------------------------------------------------------
    always_comb begin
        diff_bit = a_sr[0] ^ b_sr[0] ^ brw;
        brw_nxt  = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw);
        d_raw    = {diff_bit, res_sr[WIDTH-1:1]};
        ovf_raw  = (a_msb != b_msb) && (d_raw[WIDTH-1] != a_msb);
    end

    // ---------------------------------------------------------------
    // Operand / result shift registers, bit counter, borrow flop
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= b_in;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= d_raw;
            cnt    <= cnt + CW'(1);
            brw    <= brw_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Architectural outputs: updated only on the completion edge
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d     <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (finish) begin
`ifdef SERIAL_SUB_SAT_EN
            d     <= brw_nxt ? '0 : d_raw;
`else
            d     <= d_raw;
`endif
            b_out <= brw_nxt;
            ovf   <= ovf_raw;
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=4).
// Expected d values follow SERIAL_SUB_SAT_EN when it is defined for the build.
module tb_serial_sub;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;
    logic         ovf;

    int unsigned n_checks;
    int unsigned n_fail;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_d(input logic [W-1:0] raw, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
        return bo ? '0 : raw;
`else
        return raw;
`endif
    endfunction

    // One complete operation from IDLE; operands are scrambled right after acceptance.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                          input logic [W-1:0] raw, input logic bo, input logic ov);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        b_in  = vbin;
        @(posedge clk); #1;
        check("accept_busy", busy, 1);
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        b_in  = ~vbin;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i < W) begin
                check("run_busy", busy, 1);
                check("run_done", done, 0);
            end else begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("d", d, exp_d(raw, bo));
                check("b_out", b_out, bo);
                check("ovf", ovf, ov);
            end
        end
        @(posedge clk); #1;
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        b_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", b_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //     a      b      bin   d_raw  bo    ovf
        run_op(4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0);
        run_op(4'd3,  4'd7,  1'b0, 4'd12, 1'b1, 1'b0);
        run_op(4'd7,  4'd8,  1'b0, 4'd15, 1'b1, 1'b1);
        run_op(4'd5,  4'd5,  1'b1, 4'd15, 1'b1, 1'b0);
        run_op(4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0);
        run_op(4'd0,  4'd1,  1'b0, 4'd15, 1'b1, 1'b0);
        run_op(4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1);

        // start held high: 9-2 accepted, operands changed mid-run, 12-4 chained at DONE
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd2;
        b_in  = 1'b0;
        @(posedge clk); #1;
        check("hs_busy", busy, 1);
        a = 4'd12;
        b = 4'd4;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            check("hs_excl", busy & done, 0);
            if (i == W) begin
                check("hs_done1", done, 1);
                check("hs_d1", d, 7);
                check("hs_ovf1", ovf, 1);
            end
        end
        @(posedge clk); #1;
        check("hs_rebusy", busy, 1);
        check("hs_redone", done, 0);
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            check("hs_excl2", busy & done, 0);
            if (i == 2) check("hs_hold", d, 7);
            if (i == W) begin
                check("hs_done2", done, 1);
                check("hs_d2", d, 8);
                check("hs_ovf2", ovf, 0);
            end
        end
        @(posedge clk); #1;
        check("hs_single", done, 0);

        // asynchronous reset during the second RUN cycle
        @(negedge clk);
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_d", d, 0);
        check("mid_bout", b_out, 0);
        check("mid_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_hold_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
